inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: instruction-queue entries; power of two, 2..16.
REQ-002 Parameter MAX_OUT, default 2: maximum accepted-but-unanswered imem requests; power of two, 1..4.
REQ-003 clk  in  1  clock; all state on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 pc  in  32  current program counter from the PC register.
REQ-006 pc_en  out  1  enable to the PC register; loads the next PC.
REQ-007 redirect  in  1  branch/jump/exception taken; flush all fetch state.
REQ-008 imem_req_valid, imem_req_addr  out  1, 32  instruction-memory request and address.
REQ-009 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-010 imem_rsp_valid, imem_rsp_data  in  1, 32  in-order response and instruction word.
REQ-011 out_valid, out_inst, out_pc  out  1, 32, 32  instruction to decode, with its fetch address.
REQ-012 out_ready  in  1  decode consumes the head entry this cycle.

Function
REQ-013 Request fire = imem_req_valid & imem_req_ready; pop = out_valid & out_ready; credit = queue count + in-flight count.
REQ-014 imem_req_valid = !redirect & (in-flight < MAX_OUT) & (credit < DEPTH); imem_req_addr = pc; both combinational.
REQ-015 pc_en = fire | redirect; the PC advances exactly once per accepted request, or once on redirect.
REQ-016 On fire, pc is pushed into an in-flight address FIFO; a response pops it and writes {data, address} into the instruction queue.
REQ-017 Response-to-out_valid latency is exactly 1 cycle (registered queue, no bypass); out_inst/out_pc are driven from the head entry.
REQ-018 Push and pop in the same cycle are both performed; count is unchanged.
REQ-019 Credit accounting guarantees a free queue slot for every in-flight response; a response arriving with the queue full is an assertion failure.
REQ-020 imem_rsp_valid with no in-flight and no drop count is an assertion failure and is ignored.
REQ-021 Redirect: next cycle, queue and in-flight FIFO are empty, out_valid=0, and drop_cnt = in-flight count at the redirect, plus 1 if a fire occurred that cycle (cannot occur under REQ-014).
REQ-022 While drop_cnt > 0, each response decrements drop_cnt and is discarded; new requests may issue while drop_cnt > 0, but credit includes drop_cnt.
REQ-023 Redirect in the same cycle as a response: that response is discarded, never enters the queue.
REQ-024 Redirect in the same cycle as pop: the flush wins; decode must ignore out_* in a redirect cycle.
REQ-025 Pointers wrap modulo depth; counts are sized $clog2(depth)+1 and never wrap.

Reset
REQ-026 While rst_n=0: queue empty, in-flight empty, drop_cnt=0, out_valid=0, out_inst=0, out_pc=0.
REQ-027 While rst_n=0, imem_req_valid=0 and pc_en=0; outstanding memory responses are the memory's responsibility to squash.
REQ-028 First request may issue in the first clk edge after rst_n deasserts.

Configuration
REQ-029 Macro IFQ_PERF_CNT_EN defined: adds outputs perf_fetch (32, increments per pop) and perf_stall (32, increments per cycle with out_valid=0 and rst_n=1); both reset to 0 and wrap at 2^32.
REQ-030 Macro undefined: those ports and counters do not exist; all other behaviour is identical.

Structure
REQ-031 Package ifq_pkg holds word_t (32-bit), the entry struct {inst, pc}, and the localparam widths of counts and pointers.
REQ-032 One sub-module, ifq_fifo (parameterised width/depth, synchronous flush), is instantiated twice: in-flight addresses and the instruction queue.

Verification
REQ-033 imem always ready, 1-cycle response, out_ready=1, pc from 0x0 step 4 -> one instruction per cycle, out_pc 0x0,0x4,0x8 in order.
REQ-034 out_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 fires, then pc_en=0 and imem_req_valid=0 until a pop.
REQ-035 Two in-flight requests (0x10, 0x14), redirect to 0x100 before responses -> both responses dropped, first out_pc=0x100.
REQ-036 Redirect in the same cycle as the response for 0x20 -> 0x20 never appears on out_*, drop_cnt correct.
REQ-037 Assert rst_n mid-stream with 3 queued entries -> out_valid=0, imem_req_valid=0 immediately; refetch starts at pc=0.
REQ-038 With IFQ_PERF_CNT_EN defined: 5 pops and 3 empty cycles -> perf_fetch=5, perf_stall=3.

Source files
------------

// File: rtl/ifq_pkg.sv
// rtl/ifq_pkg.sv - shared types and width helpers for the instruction fetch queue
package ifq_pkg;

    localparam int IFQ_WORD_W      = 32;
    localparam int IFQ_DEPTH_DEF   = 4;
    localparam int IFQ_MAX_OUT_DEF = 2;

    typedef logic [IFQ_WORD_W-1:0] word_t;

    typedef struct packed {
        word_t inst;
        word_t pc;
    } ifq_entry_t;

    localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

    function automatic int ifq_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // Counts hold 0..depth inclusive, so they need one bit more than a pointer
    function automatic int ifq_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// rtl/ifq_fifo.sv - power-of-two FIFO with occupancy count and synchronous flush
module ifq_fifo
    import ifq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_flush,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_data,
    input  logic                        i_pop,
    output logic [WIDTH-1:0]            o_data,
    output logic                        o_empty,
    output logic                        o_full,
    output logic [ifq_cnt_w(DEPTH)-1:0] o_count
);

    localparam int PTR_W = ifq_ptr_w(DEPTH);
    localparam int CNT_W = ifq_cnt_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == CNT_W'(DEPTH));
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Storage is cleared on reset so the head reads as zero while empty after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - credit-based instruction fetch queue; IFQ_PERF_CNT_EN adds perf counters
module inst_fetch_queue
    import ifq_pkg::*;
#(
    parameter int DEPTH   = IFQ_DEPTH_DEF,
    parameter int MAX_OUT = IFQ_MAX_OUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef IFQ_PERF_CNT_EN
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
`endif
    input  word_t       pc,
    output logic        pc_en,
    input  logic        redirect,
    output logic        imem_req_valid,
    output word_t       imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  word_t       imem_rsp_data,
    output logic        out_valid,
    output word_t       out_inst,
    output word_t       out_pc,
    input  logic        out_ready
);

    localparam int CNT_W    = ifq_cnt_w(DEPTH);
    localparam int AF_DEPTH = (MAX_OUT < 2) ? 2 : MAX_OUT;
    localparam int AF_CNT_W = ifq_cnt_w(AF_DEPTH);
    localparam int SUM_W    = CNT_W + 2;

    logic                w_fire;
    logic                w_q_pop;
    logic                w_q_empty;
    logic                w_q_full;
    logic [CNT_W-1:0]    w_q_count;
    logic                w_af_empty;
    logic                w_af_full;
    logic [AF_CNT_W-1:0] w_af_count;
    word_t               w_af_addr;
    ifq_entry_t          w_head;
    ifq_entry_t          w_push_entry;
    logic [SUM_W-1:0]    w_credit;
    logic                w_drop_pending;
    logic                w_rsp_consume;
    logic                w_rsp_accept;
    logic [SUM_W-1:0]    w_drop_next;
    logic [CNT_W-1:0]    r_drop_cnt;

    // Credit covers queued, in-flight and to-be-dropped responses, so every accepted response has a slot
    assign w_credit       = SUM_W'(w_q_count) + SUM_W'(w_af_count) + SUM_W'(r_drop_cnt);
    assign imem_req_valid = rst_n & ~redirect
                          & (w_af_count < AF_CNT_W'(MAX_OUT))
                          & (w_credit < SUM_W'(DEPTH));
    assign imem_req_addr  = pc;
    assign w_fire         = imem_req_valid & imem_req_ready;
    assign pc_en          = rst_n & (w_fire | redirect);

    assign w_drop_pending = (r_drop_cnt != '0);
    assign w_rsp_consume  = imem_rsp_valid & (w_drop_pending | ~w_af_empty);
    assign w_rsp_accept   = imem_rsp_valid & ~redirect & ~w_drop_pending & ~w_af_empty;
    assign w_push_entry   = '{inst: imem_rsp_data, pc: w_af_addr};

    assign out_valid      = ~w_q_empty;
    assign out_inst       = w_head.inst;
    assign out_pc         = w_head.pc;
    assign w_q_pop        = out_valid & out_ready & ~redirect;

    ifq_fifo #(
        .WIDTH (IFQ_WORD_W),
        .DEPTH (AF_DEPTH)
    ) u_addr_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect),
        .i_push  (w_fire),
        .i_data  (pc),
        .i_pop   (w_rsp_accept),
        .o_data  (w_af_addr),
        .o_empty (w_af_empty),
        .o_full  (w_af_full),
        .o_count (w_af_count)
    );

    ifq_fifo #(
        .WIDTH (IFQ_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect),
        .i_push  (w_rsp_accept),
        .i_data  (w_push_entry),
        .i_pop   (w_q_pop),
        .o_data  (w_head),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_count (w_q_count)
    );

    // On redirect every older outstanding response must be dropped, less one if it lands this cycle
    always_comb begin
        w_drop_next = SUM_W'(r_drop_cnt);
        if (redirect) begin
            w_drop_next = SUM_W'(r_drop_cnt) + SUM_W'(w_af_count) + SUM_W'(w_fire)
                        - SUM_W'(w_rsp_consume);
        end else if (imem_rsp_valid && w_drop_pending) begin
            w_drop_next = SUM_W'(r_drop_cnt) - SUM_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else begin
            r_drop_cnt <= CNT_W'(w_drop_next);
        end
    end

`ifdef IFQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch <= '0;
            perf_stall <= '0;
        end else begin
            perf_fetch <= perf_fetch + 32'(w_q_pop);
            perf_stall <= perf_stall + 32'(~out_valid);
        end
    end
`endif

    a_rsp_has_slot: assert property (@(posedge clk) disable iff (!rst_n)
        w_rsp_accept |-> !w_q_full);
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rsp_valid |-> (w_drop_pending || !w_af_empty));
    a_fire_has_slot: assert property (@(posedge clk) disable iff (!rst_n)
        w_fire |-> !w_af_full);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc;
    logic        pc_en;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        out_ready;
`ifdef IFQ_PERF_CNT_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] rsp_q[$];
    logic [31:0] log_pc[$];
    logic [31:0] log_inst[$];
    logic        rsp_en;
    logic        s_fire;
    logic        s_pen;
    logic [31:0] s_addr;
    logic [31:0] tgt;
    int          fire_cnt;

    always #5 clk = ~clk;

    inst_fetch_queue u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef IFQ_PERF_CNT_EN
        .perf_fetch     (perf_fetch),
        .perf_stall     (perf_stall),
`endif
        .pc             (pc),
        .pc_en          (pc_en),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .out_valid      (out_valid),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .out_ready      (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic logic [31:0] log_at(input int i);
        if (i < log_pc.size()) return log_pc[i];
        return 32'hDEAD_DEAD;
    endfunction

    // One clock cycle: sample just after the falling edge, then model PC register and memory
    task automatic tick();
        #1;
        s_fire = imem_req_valid & imem_req_ready;
        s_pen  = pc_en;
        s_addr = imem_req_addr;
        if (s_fire) fire_cnt++;
        if (out_valid && out_ready && !redirect) begin
            log_pc.push_back(out_pc);
            log_inst.push_back(out_inst);
        end
        @(negedge clk);
        if (s_pen) pc = redirect ? tgt : pc + 32'd4;
        if (s_fire) rsp_q.push_back(s_addr);
        if (rsp_en && rsp_q.size() > 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(rsp_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    endtask

    task automatic hold_reset();
        rst_n          = 1'b0;
        redirect       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        rsp_q.delete();
        log_pc.delete();
        log_inst.delete();
        fire_cnt = 0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        pc             = 32'h0;
        imem_req_ready = 1'b1;
        rsp_en         = 1'b1;
        rst_n          = 1'b1;
    endtask

    initial begin
        int bad;
        rst_n = 1'b0; pc = 32'h0; redirect = 1'b0; tgt = 32'h0;
        imem_req_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
        out_ready = 1'b1; rsp_en = 1'b1; fire_cnt = 0;
        @(negedge clk);

        hold_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_inst", out_inst, 32'h0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
`ifdef IFQ_PERF_CNT_EN
        check("rst_perf_fetch", perf_fetch, 32'd0);
        check("rst_perf_stall", perf_stall, 32'd0);
`endif
        release_reset();

        // Streaming: two fill cycles, then one instruction per cycle
        repeat (9) tick();
        check("stream_cnt", 32'(log_pc.size()), 32'd7);
        for (int i = 0; i < 7; i++) check($sformatf("stream_pc%0d", i), log_at(i), 32'(i * 4));
        check("stream_inst0", (log_inst.size() > 0) ? log_inst[0] : 32'hDEAD_DEAD, 32'hC0DE_0000);

        // Decode stalled: credit limits fires to DEPTH
        hold_reset();
        release_reset();
        out_ready = 1'b0;
        repeat (10) tick();
        check("stall_fires", 32'(fire_cnt), 32'd4);
        check("stall_req_valid", 32'(s_fire), 32'd0);
        check("stall_pc_en", 32'(s_pen), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        tick();
        check("stall_pop_pc", log_at(0), 32'h0);
        check("stall_pop_pc_en", 32'(s_pen), 32'd0);
        out_ready = 1'b0;

        // Reset with three entries queued
        hold_reset();
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        check("midrst_pc_en", 32'(pc_en), 32'd0);
        release_reset();
        out_ready = 1'b1;
        repeat (4) tick();
        check("midrst_pc0", log_at(0), 32'h0);
        check("midrst_pc1", log_at(1), 32'h4);

        // Two in flight, redirect before either responds
        hold_reset();
        release_reset();
        pc = 32'h10;
        rsp_en = 1'b0;
        tick();
        tick();
        tick();
        check("r35_max_out", 32'(s_fire), 32'd0);
        redirect = 1'b1;
        tgt = 32'h100;
        tick();
        check("r35_redir_pc_en", 32'(s_pen), 32'd1);
        check("r35_redir_fire", 32'(s_fire), 32'd0);
        redirect = 1'b0;
        rsp_en = 1'b1;
        repeat (6) tick();
        check("r35_first_pc", log_at(0), 32'h100);
        check("r35_first_inst", (log_inst.size() > 0) ? log_inst[0] : 32'hDEAD_DEAD, 32'hC0DE_0100);
        check("r35_cnt", 32'(log_pc.size()), 32'd2);
        check("r35_second_pc", log_at(1), 32'h104);

        // Redirect in the same cycle as the response for 0x20
        hold_reset();
        release_reset();
        pc = 32'h20;
        rsp_en = 1'b0;
        tick();
        rsp_en = 1'b1;
        tick();
        check("r36_rsp_present", 32'(imem_rsp_valid), 32'd1);
        check("r36_rsp_data", imem_rsp_data, 32'hC0DE_0020);
        rsp_en = 1'b0;
        redirect = 1'b1;
        tgt = 32'h200;
        tick();
        redirect = 1'b0;
        rsp_en = 1'b1;
        repeat (6) tick();
        check("r36_first_pc", log_at(0), 32'h200);
        check("r36_second_pc", log_at(1), 32'h204);
        bad = 0;
        foreach (log_pc[i]) if (log_pc[i] == 32'h20 || log_pc[i] == 32'h24) bad++;
        check("r36_no_stale", 32'(bad), 32'd0);

`ifdef IFQ_PERF_CNT_EN
        hold_reset();
        release_reset();
        out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            imem_req_ready = (c < 5);
            tick();
        end
        check("perf_fetch", perf_fetch, 32'd5);
        check("perf_stall", perf_stall, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
